// File: rtl/led_comet_pwm.sv
// led_comet_pwm: per-channel PWM LED driver; lit positions load to peak and fade out in steps,
// leaving a comet tail behind the moving dot. Duty is shadowed once per frame.
module led_comet_pwm #(
    parameter int CH         = 8,
    parameter int PWM_BITS   = 8,
    parameter int DECAY_DIV  = 50000,
    parameter int DECAY_STEP = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [CH-1:0]       pattern_in,
    input  logic [PWM_BITS-1:0] peak,
    output logic [CH-1:0]       pwm_out,
    output logic                frame_start
);
    localparam int DW = DECAY_DIV > 1 ? $clog2(DECAY_DIV) : 1;
    localparam logic [DW-1:0] DEC_LAST = DW'(DECAY_DIV - 1);
    localparam logic [PWM_BITS-1:0] STEP = PWM_BITS'(DECAY_STEP);

    logic [PWM_BITS-1:0]          pwm_cnt;
    logic [DW-1:0]                dec_cnt;
    logic [CH-1:0][PWM_BITS-1:0]  level;
    logic [CH-1:0][PWM_BITS-1:0]  duty;
    logic                         decay_tick;
    logic                         frame_end;

    assign decay_tick = en && dec_cnt == DEC_LAST;
    assign frame_end  = en && pwm_cnt == '1;

    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_cnt     <= '0;
            dec_cnt     <= '0;
            level       <= '0;
            duty        <= '0;
            pwm_out     <= '0;
            frame_start <= 1'b0;
        end else begin
            pwm_cnt     <= en ? pwm_cnt + 1'b1 : '0;
            dec_cnt     <= (!en || decay_tick) ? '0 : dec_cnt + 1'b1;
            frame_start <= en && pwm_cnt == '0;
            for (int i = 0; i < CH; i++) begin
                pwm_out[i] <= en && pwm_cnt < duty[i];
                if (frame_end)
                    duty[i] <= level[i];
                // a load wins over a coincident decay tick; decay saturates at zero
                level[i] <= pattern_in[i] ? peak :
                            decay_tick ? (level[i] > STEP ? level[i] - STEP : '0) :
                            level[i];
            end
        end
    end
endmodule

// File: tb/tb_led_comet_pwm.sv
// tb_led_comet_pwm: directed scoreboard bench; expectations are queued with the cycle they fall
// due, and a negedge monitor compares single-cycle samples and per-frame high counts.
module tb_led_comet_pwm;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b1;
    logic [7:0] pattern_in = '0;
    logic [3:0] peak = '0;
    logic [7:0] pwm_out;
    logic       frame_start;

    int cyc = 0;
    int tests = 0;
    int fails = 0;
    logic [7:0] hist_pwm [0:1023];
    logic       hist_fs  [0:1023];

    typedef struct {
        string           name;
        int              due;
        bit              frame;
        int              at;
        logic [7:0]      pwm;
        logic            fs;
        logic [7:0][4:0] cnt;
    } exp_t;
    exp_t q[$];

    led_comet_pwm #(.CH(8), .PWM_BITS(4), .DECAY_DIV(4), .DECAY_STEP(3)) dut (
        .clk(clk), .rst(rst), .en(en), .pattern_in(pattern_in), .peak(peak),
        .pwm_out(pwm_out), .frame_start(frame_start)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic step_to(input int k);
        while (cyc < k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_s(input string n, input int c, input logic [7:0] p, input logic f);
        exp_t e;
        e.name = n; e.frame = 0; e.at = c; e.due = c; e.pwm = p; e.fs = f; e.cnt = '0;
        q.push_back(e);
    endtask

    task automatic push_f(input string n, input int f, input int ca, input int va, input int cb, input int vb);
        exp_t e;
        e.name = n; e.frame = 1; e.at = f; e.due = f + 15; e.pwm = '0; e.fs = 1'b1; e.cnt = '0;
        if (ca >= 0) e.cnt[ca] = 5'(va);
        if (cb >= 0) e.cnt[cb] = 5'(vb);
        q.push_back(e);
    endtask

    task automatic check(input exp_t e);
        logic [7:0][4:0] got;
        logic fs_ok;
        string s;
        tests++;
        if (!e.frame) begin
            if (hist_pwm[e.at] !== e.pwm || hist_fs[e.at] !== e.fs) begin
                fails++;
                $display("FAIL %s @%0d: pwm_out=%h frame_start=%b, expected pwm_out=%h frame_start=%b",
                         e.name, e.at, hist_pwm[e.at], hist_fs[e.at], e.pwm, e.fs);
            end
        end else begin
            got = '0;
            fs_ok = 1'b1;
            for (int j = 0; j < 16; j++) begin
                if (hist_fs[e.at + j] !== (j == 0)) fs_ok = 1'b0;
                for (int c = 0; c < 8; c++)
                    if (hist_pwm[e.at + j][c] === 1'b1) got[c] = got[c] + 5'd1;
            end
            if (got !== e.cnt || !fs_ok) begin
                fails++;
                s = "";
                for (int c = 0; c < 8; c++) s = {s, $sformatf(" %0d/%0d", got[c], e.cnt[c])};
                $display("FAIL %s frame@%0d: high counts ch0..7 actual/expected%s, frame_start cadence %s",
                         e.name, e.at, s, fs_ok ? "ok" : "bad");
            end
        end
    endtask

    always @(negedge clk) begin
        if (cyc >= 1 && cyc < 1024) begin
            hist_pwm[cyc] = pwm_out;
            hist_fs[cyc]  = frame_start;
        end
        for (int i = q.size() - 1; i >= 0; i--)
            if (q[i].due == cyc) begin
                check(q[i]);
                q.delete(i);
            end
    end

    initial begin
        int loads[4] = '{118, 130, 142, 154};
        int wf[11]  = '{232, 248, 264, 280, 296, 312, 328, 344, 360, 376, 392};
        int wa[11]  = '{  0,   0,   1,   2,   2,   3,   4,   5,   6,   6,   0};
        int wva[11] = '{ 15,   9,  12,  15,   3,   6,   9,  12,  15,   3,  15};
        int wb[11]  = '{ -1,   1,   2,   3,   3,   4,   5,   6,   7,   7,   7};
        int wvb[11] = '{  0,  15,  15,  15,  15,  15,  15,  15,  15,  15,   6};
        push_s("reset_c1", 1, 8'h00, 1'b0);
        push_s("reset_c2", 2, 8'h00, 1'b0);
        push_s("first_fs", 3, 8'h00, 1'b1);
        push_s("fs_one_cycle", 4, 8'h00, 1'b0);
        push_f("idle_f3", 3, -1, 0, -1, 0);
        push_f("idle_f19", 19, -1, 0, -1, 0);
        step_to(2);
        rst = 1'b0;
        push_f("ch0_full_f35", 35, 0, 15, -1, 0);
        push_f("ch0_full_f51", 51, 0, 15, -1, 0);
        push_s("ch0_on_c70", 70, 8'h01, 1'b0);
        step_to(20);
        pattern_in = 8'h01;
        peak = 4'd15;
        push_s("midrst_dark", 71, 8'h00, 1'b0);
        push_s("restart_fs", 72, 8'h00, 1'b1);
        push_f("post_rst_f72", 72, -1, 0, -1, 0);
        push_f("post_rst_f88", 88, -1, 0, -1, 0);
        step_to(70);
        rst = 1'b1;
        pattern_in = 8'h00;
        step_to(71);
        rst = 1'b0;
        push_f("fade_pulse_f104", 104, 2, 1, -1, 0);
        push_f("fade_lvl10_f120", 120, 2, 10, -1, 0);
        push_f("fade_lvl7_f136", 136, 2, 7, -1, 0);
        push_f("fade_lvl4_f152", 152, 2, 4, -1, 0);
        push_f("fade_lvl1_f168", 168, 2, 1, -1, 0);
        push_f("fade_sat0_f184", 184, -1, 0, -1, 0);
        step_to(88);
        pattern_in = 8'h04;
        peak = 4'd10;
        step_to(89);
        pattern_in = 8'h00;
        for (int k = 0; k < 4; k++) begin
            step_to(loads[k] - 1);
            pattern_in = 8'h04;
            step_to(loads[k]);
            pattern_in = 8'h00;
        end
        push_f("load_beats_tick", 200, 5, 15, -1, 0);
        push_f("ch5_fade_f216", 216, 5, 3, -1, 0);
        step_to(185);
        pattern_in = 8'h20;
        peak = 4'd12;
        step_to(186);
        pattern_in = 8'h00;
        step_to(194);
        pattern_in = 8'h20;
        peak = 4'd15;
        step_to(195);
        pattern_in = 8'h00;
        for (int k = 0; k < 11; k++)
            push_f($sformatf("walk_f%0d", wf[k]), wf[k], wa[k], wva[k], wb[k], wvb[k]);
        for (int s = 0; s < 9; s++) begin
            step_to(215 + 20 * s);
            pattern_in = 8'(1 << (s % 8));
        end
        push_f("hold_f408", 408, 0, 15, -1, 0);
        push_s("pre_dis_c428", 428, 8'h01, 1'b0);
        push_s("dis_dark_c429", 429, 8'h00, 1'b0);
        push_s("dis_dark_c430", 430, 8'h00, 1'b0);
        push_s("reen_fs_c437", 437, 8'h01, 1'b1);
        push_s("reen_c438", 438, 8'h01, 1'b0);
        push_f("reen_f437", 437, 0, 15, -1, 0);
        push_f("reen_f453", 453, 0, 15, -1, 0);
        step_to(428);
        en = 1'b0;
        step_to(436);
        en = 1'b1;
        step_to(472);
        foreach (q[i]) begin
            tests++;
            fails++;
            $display("FAIL %s: never compared, due cycle %0d, run ended at %0d", q[i].name, q[i].due, cyc);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
